// File: rtl/cache_mem_responder_pkg.sv
// Shared types and width helpers for the block memory responder.
// Imported by the responder and anything that sizes its ports.
package cache_mem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CNT_W = 8;

    function automatic int block_width(input int line, input int blk);
        return (1 << blk) * line;
    endfunction

    function automatic int block_addr_width(input int addr, input int blk);
        return addr - blk - 2;
    endfunction

endpackage

// File: rtl/cache_mem_responder.sv
// Fixed-latency block memory behind the cache: one request at a time,
// busywait while in flight, single-cycle read/write done pulse.
module cache_mem_responder
    import cache_mem_responder_pkg::*;
#(
    parameter int c_line_size  = 32,
    parameter int c_block_size = 2,
    parameter int address_size = 32,
    parameter int depth_bits   = 6,
    parameter int mem_latency  = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic m_read_i,
    input  logic m_wr_i,
    input  logic [block_addr_width(address_size, c_block_size)-1:0] m_address_i,
    input  logic [block_width(c_line_size, c_block_size)-1:0] m_write_data_i,
    output logic [block_width(c_line_size, c_block_size)-1:0] m_read_data_o,
    output logic m_busywait_o,
    output logic m_read_done_o,
    output logic m_write_done_o
);

    localparam int BW    = block_width(c_line_size, c_block_size);
    localparam int AW    = block_addr_width(address_size, c_block_size);
    localparam int DEPTH = 1 << depth_bits;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(mem_latency - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic                    op_wr;
    logic [depth_bits-1:0]   idx;
    logic [BW-1:0]           wdata;
    logic [BW-1:0]           mem [0:DEPTH-1];

    // Upper block-address bits alias onto the same entries.
    logic unused_addr_bits;
    assign unused_addr_bits = ^m_address_i[AW-1:depth_bits];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state          <= S_IDLE;
            cnt            <= '0;
            op_wr          <= 1'b0;
            idx            <= '0;
            wdata          <= '0;
            m_read_data_o  <= '0;
            m_busywait_o   <= 1'b0;
            m_read_done_o  <= 1'b0;
            m_write_done_o <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (m_wr_i || m_read_i) begin
                        op_wr        <= m_wr_i;
                        idx          <= m_address_i[depth_bits-1:0];
                        cnt          <= CNT_INIT;
                        state        <= S_BUSY;
                        m_busywait_o <= 1'b1;
                        if (m_wr_i) begin
                            wdata <= m_write_data_i;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt == '0) begin
                        if (op_wr) begin
                            mem[idx] <= wdata;
                        end else begin
                            m_read_data_o <= mem[idx];
                        end
                        state          <= S_DONE;
                        m_busywait_o   <= 1'b0;
                        m_write_done_o <= op_wr;
                        m_read_done_o  <= !op_wr;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state          <= S_IDLE;
                    m_write_done_o <= 1'b0;
                    m_read_done_o  <= 1'b0;
                end
                default: begin
                    state          <= S_IDLE;
                    m_busywait_o   <= 1'b0;
                    m_write_done_o <= 1'b0;
                    m_read_done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
